acc_v3: RTL and testbench

Next-generation output accumulator between the systolic array and the output global buffer. Each of PE_SIZE column lanes holds an ACC_DEPTH-entry circular accumulation buffer. The buffer sums partial-sum rows over a programmable number of K-tile passes, then drains the finished rows through a valid/ready port. Each drained value is quantized with programmable round-shift, saturation and optional ReLU.

---
 rtl/acc_v3.sv | 218 +++++++++++++++++++++
 tb/tb_acc_v3.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_v3.sv
// Output accumulator: per-lane circular buffers sum K-tile partial-sum passes, then drain quantized rows.
// Latency: the first row is valid two cycles after the last lane's last write; one row per cycle while ready is held.
// Backpressure: ofmap_valid_o && !ofmap_ready_i holds the presented row stable; there is no backpressure on psum input.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_start_i                   start pulse (IDLE only); latches cfg_pass_num_i, cfg_shift_i, cfg_relu_i
//   psum_en_i, psum_row_i         per-lane skewed partial sums, lane 0 in the MSB slice
//   ofmap_row_o, ofmap_valid_o,
//   ofmap_ready_i                 quantized output rows, lane 0 in the MSB slice
//   busy_o, done_o, err_o         status: ACCUM/DRAIN, end-of-tile pulse, sticky misuse flag
module acc_v3 #(
  parameter int PE_SIZE    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int ACC_DEPTH  = 4,
  parameter int PASS_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start_i,
  input  logic [PASS_WIDTH-1:0]            cfg_pass_num_i,
  input  logic [4:0]                       cfg_shift_i,
  input  logic                             cfg_relu_i,
  input  logic [PE_SIZE-1:0]               psum_en_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0]    psum_row_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0]    ofmap_row_o,
  output logic                             ofmap_valid_o,
  input  logic                             ofmap_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);

  localparam int PTR_W = $clog2(ACC_DEPTH);
  localparam int QW    = PSUM_WIDTH + 1;
  localparam logic [PTR_W-1:0]     LAST_ROW = PTR_W'(ACC_DEPTH - 1);
  localparam logic signed [QW-1:0] QMAX     = QW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [QW-1:0] QMIN     = QW'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  // Latched configuration
  logic [PASS_WIDTH-1:0] pass_num;
  logic [4:0]            shift;
  logic                  relu;

  // Per-lane write side
  logic [PTR_W-1:0]             wptr     [PE_SIZE];
  logic [PASS_WIDTH-1:0]        pass_cnt [PE_SIZE];
  logic signed [PSUM_WIDTH-1:0] mem      [PE_SIZE][ACC_DEPTH];

  // Drain side: rptr is the index of the row currently presented (or about to be)
  logic [PTR_W-1:0] rptr;

  logic [PASS_WIDTH-1:0]        pass_target;
  logic [PE_SIZE-1:0]           lane_done;
  logic [PE_SIZE-1:0]           wr_en;
  logic signed [PSUM_WIDTH-1:0] wr_data [PE_SIZE];
  logic [PTR_W-1:0]             load_idx;
  logic [DATA_WIDTH*PE_SIZE-1:0] row_next;
  logic                         start_acc;
  logic                         hs;
  logic                         last_hs;

  // Round half toward +inf, arithmetic shift, saturate, optional ReLU.
  // One extra bit of headroom keeps acc + rounding constant from overflowing.
  function automatic logic [DATA_WIDTH-1:0] quant(
    input logic signed [PSUM_WIDTH-1:0] acc,
    input logic [4:0]                   sh,
    input logic                         rl
  );
    logic signed [QW-1:0]  ext;
    logic signed [QW-1:0]  rnd;
    logic signed [QW-1:0]  t;
    logic [DATA_WIDTH-1:0] q;
    ext = QW'(acc);
    rnd = '0;
    if (sh != 5'd0) rnd = QW'(1) << (sh - 5'd1);
    t = (ext + rnd) >>> sh;
    if (t > QMAX)      q = QMAX[DATA_WIDTH-1:0];
    else if (t < QMIN) q = QMIN[DATA_WIDTH-1:0];
    else               q = t[DATA_WIDTH-1:0];
    if (rl && q[DATA_WIDTH-1]) q = '0;
    return q;
  endfunction

  // A programmed pass count of zero behaves as a single pass
  assign pass_target = (pass_num == '0) ? PASS_WIDTH'(1) : pass_num;

  // Read-modify-write per lane; pass 0 forces the feedback to zero so stale
  // buffer contents from an earlier or aborted tile never leak in.
  always_comb begin
    lane_done = '0;
    wr_en     = '0;
    for (int j = 0; j < PE_SIZE; j++) begin
      wr_data[j] = '0;
    end
    for (int j = 0; j < PE_SIZE; j++) begin
      lane_done[j] = (pass_cnt[j] >= pass_target);
      wr_en[j]     = psum_en_i[j] && (state == ACCUM) && !lane_done[j];
      wr_data[j]   = ((pass_cnt[j] == '0) ? '0 : mem[j][wptr[j]])
                   + psum_row_i[PSUM_WIDTH*(PE_SIZE-j)-1 -: PSUM_WIDTH];
    end
  end

  assign hs      = ofmap_valid_o && ofmap_ready_i;
  assign last_hs = hs && (rptr == LAST_ROW);

  // While a row is presented, the next load (on handshake) is the following row
  assign load_idx = ofmap_valid_o ? (rptr + PTR_W'(1)) : rptr;

  always_comb begin
    row_next = '0;
    for (int j = 0; j < PE_SIZE; j++) begin
      row_next[DATA_WIDTH*(PE_SIZE-j)-1 -: DATA_WIDTH] = quant(mem[j][load_idx], shift, relu);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start_i) begin
          state_next = ACCUM;
          start_acc  = 1'b1;
        end
      end
      ACCUM: begin
        if (&lane_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  // Control, pointers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_num      <= '0;
      shift         <= '0;
      relu          <= 1'b0;
      rptr          <= '0;
      ofmap_valid_o <= 1'b0;
      ofmap_row_o   <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      for (int j = 0; j < PE_SIZE; j++) begin
        wptr[j]     <= '0;
        pass_cnt[j] <= '0;
      end
    end else begin
      done_o <= 1'b0;

      // Any enable that did not turn into a buffer write is misuse
      if (|(psum_en_i & ~wr_en)) err_o <= 1'b1;

      if (start_acc) begin
        pass_num <= cfg_pass_num_i;
        shift    <= cfg_shift_i;
        relu     <= cfg_relu_i;
        rptr     <= '0;
        for (int j = 0; j < PE_SIZE; j++) begin
          wptr[j]     <= '0;
          pass_cnt[j] <= '0;
        end
      end

      for (int j = 0; j < PE_SIZE; j++) begin
        if (wr_en[j]) begin
          wptr[j] <= wptr[j] + PTR_W'(1);
          if (wptr[j] == LAST_ROW) pass_cnt[j] <= pass_cnt[j] + PASS_WIDTH'(1);
        end
      end

      if (state == DRAIN) begin
        if (!ofmap_valid_o) begin
          ofmap_row_o   <= row_next;
          ofmap_valid_o <= 1'b1;
        end else if (ofmap_ready_i) begin
          if (rptr == LAST_ROW) begin
            ofmap_valid_o <= 1'b0;
            done_o        <= 1'b1;
          end else begin
            rptr        <= rptr + PTR_W'(1);
            ofmap_row_o <= row_next;
          end
        end
      end
    end
  end

  // Accumulation buffer storage, intentionally not reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < PE_SIZE; j++) begin
      if (wr_en[j] && !rst) mem[j][wptr[j]] <= wr_data[j];
    end
  end

endmodule

// File: tb/tb_acc_v3.sv
// Directed bench for acc_v3: single/multi-pass accumulation, rounding,
// saturation/ReLU, output backpressure, abort by reset and error flag.
module tb_acc_v3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start_i;
  logic [7:0]  cfg_pass_num_i;
  logic [4:0]  cfg_shift_i;
  logic        cfg_relu_i;
  logic [3:0]  psum_en_i;
  logic [127:0] psum_row_i;
  logic [31:0] ofmap_row_o;
  logic        ofmap_valid_o;
  logic        ofmap_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] tile    [4][4];  // [row][lane]
  logic [31:0] exp_row [4];

  acc_v3 dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start_i   (cfg_start_i),
    .cfg_pass_num_i(cfg_pass_num_i),
    .cfg_shift_i   (cfg_shift_i),
    .cfg_relu_i    (cfg_relu_i),
    .psum_en_i     (psum_en_i),
    .psum_row_i    (psum_row_i),
    .ofmap_row_o   (ofmap_row_o),
    .ofmap_valid_o (ofmap_valid_o),
    .ofmap_ready_i (ofmap_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input int r, input int a, input int b, input int c, input int d);
    tile[r][0] = a;
    tile[r][1] = b;
    tile[r][2] = c;
    tile[r][3] = d;
  endtask

  task automatic start(input int p, input int s, input logic rl);
    cfg_start_i    = 1'b1;
    cfg_pass_num_i = 8'(p);
    cfg_shift_i    = 5'(s);
    cfg_relu_i     = rl;
    tick();
    cfg_start_i    = 1'b0;
  endtask

  // One full pass over the tile with lane j lagging lane 0 by j cycles
  task automatic drive_pass();
    for (int t = 0; t < 7; t++) begin
      psum_en_i  = '0;
      psum_row_i = '0;
      for (int j = 0; j < 4; j++) begin
        if ((t - j) >= 0 && (t - j) < 4) begin
          psum_en_i[j] = 1'b1;
          psum_row_i[32*(4-j)-1 -: 32] = tile[t-j][j];
        end
      end
      tick();
    end
    psum_en_i  = '0;
    psum_row_i = '0;
  endtask

  // Drain with ready held high and compare all four rows plus done/busy
  task automatic drain_expect(input string tag);
    int waitc;
    waitc = 0;
    ofmap_ready_i = 1'b1;
    while (!ofmap_valid_o && waitc < 20) begin
      tick();
      waitc++;
    end
    chk({tag, "_valid_rise"}, 32'(ofmap_valid_o), 32'd1);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("%s_row%0d", tag, r), ofmap_row_o, exp_row[r]);
      chk($sformatf("%s_nodone%0d", tag, r), 32'(done_o), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
    chk({tag, "_valid_fall"}, 32'(ofmap_valid_o), 32'd0);
    tick();
    chk({tag, "_done_once"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    cfg_start_i    = 1'b0;
    cfg_pass_num_i = '0;
    cfg_shift_i    = '0;
    cfg_relu_i     = 1'b0;
    psum_en_i      = '0;
    psum_row_i     = '0;
    ofmap_ready_i  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(ofmap_valid_o), 32'd0);
    chk("rst_row",   ofmap_row_o,        32'd0);
    chk("rst_busy",  32'(busy_o),        32'd0);
    chk("rst_done",  32'(done_o),        32'd0);
    chk("rst_err",   32'(err_o),         32'd0);
    rst = 1'b0;
    tick();

    // Single pass, identity quantization
    for (int r = 0; r < 4; r++) set_row(r, 4*r, 4*r+1, 4*r+2, 4*r+3);
    exp_row[0] = 32'h00010203;
    exp_row[1] = 32'h04050607;
    exp_row[2] = 32'h08090a0b;
    exp_row[3] = 32'h0c0d0e0f;
    start(1, 0, 1'b0);
    chk("p1_busy", 32'(busy_o), 32'd1);
    drive_pass();
    chk("p1_no_early_valid", 32'(ofmap_valid_o), 32'd0);
    drain_expect("p1");
    chk("p1_err_clean", 32'(err_o), 32'd0);

    // Three passes of 10 with shift 2 -> (30+2)>>>2 = 8
    for (int r = 0; r < 4; r++) set_row(r, 10, 10, 10, 10);
    for (int r = 0; r < 4; r++) exp_row[r] = 32'h08080808;
    start(3, 2, 1'b0);
    drive_pass();
    chk("mp_pass1_novalid", 32'(ofmap_valid_o), 32'd0);
    drive_pass();
    chk("mp_pass2_novalid", 32'(ofmap_valid_o), 32'd0);
    drive_pass();
    chk("mp_pass3_novalid", 32'(ofmap_valid_o), 32'd0);
    tick();
    chk("mp_drain_novalid", 32'(ofmap_valid_o), 32'd0);
    drain_expect("mp");

    // Rounding half toward +inf, shift 2
    set_row(0, 6, -6, 5, -2);
    set_row(1, 7, -7, 1, -1);
    set_row(2, 2, -3, 0, 3);
    set_row(3, 100, -100, 1000, -1000);
    exp_row[0] = 32'h02ff0100;
    exp_row[1] = 32'h02fe0000;
    exp_row[2] = 32'h01ff0001;
    exp_row[3] = 32'h19e77f80;
    start(1, 2, 1'b0);
    drive_pass();
    drain_expect("rnd");

    // Saturation, then the same data with ReLU
    set_row(0, 1000, -1000, 127, -128);
    set_row(1, 128, -129, 0, -1);
    set_row(2, -5, 5, -128, 64);
    set_row(3, 32'h7fffffff, 32'h80000000, 1, 2);
    exp_row[0] = 32'h7f807f80;
    exp_row[1] = 32'h7f8000ff;
    exp_row[2] = 32'hfb058040;
    exp_row[3] = 32'h7f800102;
    start(1, 0, 1'b0);
    drive_pass();
    drain_expect("sat");
    exp_row[0] = 32'h7f007f00;
    exp_row[1] = 32'h7f000000;
    exp_row[2] = 32'h00050040;
    exp_row[3] = 32'h7f000102;
    start(1, 0, 1'b1);
    drive_pass();
    drain_expect("relu");

    // Backpressure on row 1 for three cycles
    for (int r = 0; r < 4; r++) set_row(r, 16*r, 16*r+1, 16*r+2, 16*r+3);
    start(1, 0, 1'b0);
    drive_pass();
    ofmap_ready_i = 1'b1;
    for (int w = 0; w < 20 && !ofmap_valid_o; w++) tick();
    chk("bp_row0", ofmap_row_o, 32'h00010203);
    tick();
    ofmap_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_hold%0d_row", k), ofmap_row_o, 32'h10111213);
      chk($sformatf("bp_hold%0d_valid", k), 32'(ofmap_valid_o), 32'd1);
      tick();
    end
    chk("bp_hold3_row", ofmap_row_o, 32'h10111213);
    ofmap_ready_i = 1'b1;
    tick();
    chk("bp_row2", ofmap_row_o, 32'h20212223);
    tick();
    chk("bp_row3", ofmap_row_o, 32'h30313233);
    chk("bp_nodone", 32'(done_o), 32'd0);
    tick();
    chk("bp_done", 32'(done_o), 32'd1);
    chk("bp_valid_fall", 32'(ofmap_valid_o), 32'd0);
    tick();
    chk("bp_done_once", 32'(done_o), 32'd0);

    // Abort mid-accumulation, then a clean single-pass run over stale entries
    start(2, 0, 1'b0);
    psum_en_i  = 4'b1111;
    psum_row_i = {4{32'd99}};
    tick();
    tick();
    psum_en_i  = '0;
    psum_row_i = '0;
    chk("ab_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ab_busy", 32'(busy_o), 32'd0);
    chk("ab_valid", 32'(ofmap_valid_o), 32'd0);
    for (int r = 0; r < 4; r++) set_row(r, 10*r, 10*r-1, 10*r-2, 10*r-3);
    exp_row[0] = 32'h00fffefd;
    exp_row[1] = 32'h0a090807;
    exp_row[2] = 32'h14131211;
    exp_row[3] = 32'h1e1d1c1b;
    start(1, 0, 1'b0);
    drive_pass();
    drain_expect("ab");

    // psum_en_i in IDLE sets a sticky error cleared only by reset
    chk("err_pre", 32'(err_o), 32'd0);
    psum_en_i = 4'b0001;
    tick();
    psum_en_i = '0;
    chk("err_set", 32'(err_o), 32'd1);
    tick();
    tick();
    tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", 32'(err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
